// File: rtl/game_pkg.sv
// Types and constants shared by the mole scheduler, the top-level game controller
// and the matrix display controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        LIVE,
        BOOM,
        GAP
    } mole_state_e;

    // Colour doubles as point value; a live mole is never COLOR_NONE.
    localparam logic [1:0] COLOR_NONE   = 2'b00;
    localparam logic [1:0] COLOR_GREEN  = 2'b01;
    localparam logic [1:0] COLOR_RED    = 2'b10;
    localparam logic [1:0] COLOR_YELLOW = 2'b11;

    localparam int                LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h81;

    localparam int                 LEVEL_W   = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

    localparam int TIMER_W = 12;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
        return {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
    endfunction

    // Lifetime shrinks by step per level down to floor_ms; compared before subtracting
    // so a large level never wraps the unsigned result.
    function automatic int unsigned life_ms(input logic [LEVEL_W-1:0] lvl,
                                            input int unsigned base_ms,
                                            input int unsigned step_ms,
                                            input int unsigned floor_ms);
        int unsigned cut;
        cut = 32'(lvl) * step_ms;
        if (cut >= base_ms - floor_ms) return floor_ms;
        return base_ms - cut;
    endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Event bus between the mole scheduler (master) and the game/display controllers (slave),
// including the explosion request/done handshake.
interface mole_scheduler_if;
    import game_pkg::*;

    logic               spawn;
    logic [3:0]         pos;
    logic [1:0]         color;
    logic               boom_req;
    logic               boom_done;
    logic               hit_strobe;
    logic [1:0]         hit_pts;
    logic               miss_strobe;
    logic [LEVEL_W-1:0] level;

    modport master (
        output spawn, pos, color, boom_req, hit_strobe, hit_pts, miss_strobe, level,
        input  boom_done
    );

    modport slave (
        input  spawn, pos, color, boom_req, hit_strobe, hit_pts, miss_strobe, level,
        output boom_done
    );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (feedback r[7]^r[0]) with a synchronous active-low seed load;
// advances every cycle outside reset.
module lfsr8
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;
    logic [LFSR_W-1:0] r_d;

    always_comb r_d = lfsr_next(r_q);

    // NOTE: state updates use <= so every flop samples pre-edge values; = here would race.
    always_ff @(posedge clk) begin
        if (!rst_n) r_q <= SEED;
        else        r_q <= r_d;
    end

    assign q = r_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: spawns moles, times lifetime and gap, judges hits, hands off
// the explosion and raises the level. Define MOLE_SCHED_MISS_PENALTY_EN to make a wrong key end the mole.
module mole_scheduler
    import game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'h01,
    parameter int unsigned       BASE_LIFE_MS   = 1000,
    parameter int unsigned       LIFE_STEP_MS   = 100,
    parameter int unsigned       MIN_LIFE_MS    = 300,
    parameter int unsigned       GAP_MS         = 200,
    parameter int unsigned       HITS_PER_LEVEL = 5,
    parameter int unsigned       BOOM_TIMEOUT   = 255
) (
    input  logic             clk1k,
    input  logic             rst_n,
    input  logic             run,
    input  logic [15:0]      key,
    mole_scheduler_if.master bus
);

    localparam int HIT_CNT_W = $clog2(HITS_PER_LEVEL + 1);

    mole_state_e          state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 armed_q, armed_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic                 spawn_q, spawn_d;
    logic [3:0]           pos_q, pos_d;
    logic [1:0]           color_q, color_d;
    logic                 boom_req_q, boom_req_d;
    logic                 hit_strobe_q, hit_strobe_d;
    logic [1:0]           hit_pts_q, hit_pts_d;
    logic                 miss_strobe_q, miss_strobe_d;

    logic [LFSR_W-1:0]  lfsr;
    logic [15:0]        onehot;
    logic               key_hit;
    logic               wrong_key;
    logic [TIMER_W-1:0] life_m1;
    logic               unused_lfsr_bits;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk1k),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr[3:2];
    assign onehot  = 16'd1 << pos_q;
    assign key_hit = armed_q && (key == onehot);
    assign life_m1 = TIMER_W'(life_ms(level_q, BASE_LIFE_MS, LIFE_STEP_MS, MIN_LIFE_MS) - 32'd1);

`ifdef MOLE_SCHED_MISS_PENALTY_EN
    assign wrong_key = armed_q && (key != '0) && (key != onehot);
`else
    assign wrong_key = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave one unassigned (no latches).
        state_d       = state_q;
        timer_d       = timer_q;
        armed_d       = armed_q;
        level_d       = level_q;
        hit_cnt_d     = hit_cnt_q;
        spawn_d       = 1'b0;
        pos_d         = pos_q;
        color_d       = color_q;
        boom_req_d    = boom_req_q;
        hit_strobe_d  = 1'b0;
        hit_pts_d     = hit_pts_q;
        miss_strobe_d = 1'b0;

        if (key == '0) armed_d = 1'b1;

        if (!run) begin
            // Leaving the round swallows any hit or expiry judged in this same cycle.
            state_d    = IDLE;
            boom_req_d = 1'b0;
            level_d    = '0;
            hit_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    level_d   = '0;
                    hit_cnt_d = '0;
                    state_d   = SPAWN;
                end
                SPAWN: begin
                    spawn_d = 1'b1;
                    pos_d   = lfsr[7:4];
                    color_d = {lfsr[1], ~lfsr[1] | lfsr[0]};
                    timer_d = life_m1;
                    state_d = LIVE;
                end
                LIVE: begin
                    if (key_hit) begin
                        state_d      = BOOM;
                        hit_strobe_d = 1'b1;
                        hit_pts_d    = color_q;
                        boom_req_d   = 1'b1;
                        armed_d      = 1'b0;
                        timer_d      = TIMER_W'(BOOM_TIMEOUT - 32'd1);
                        if (32'(hit_cnt_q) + 32'd1 >= HITS_PER_LEVEL) begin
                            hit_cnt_d = '0;
                            if (level_q != LEVEL_MAX) level_d = level_q + LEVEL_W'(1);
                        end else begin
                            hit_cnt_d = hit_cnt_q + HIT_CNT_W'(1);
                        end
                    end else if (wrong_key || timer_q == '0) begin
                        state_d       = GAP;
                        miss_strobe_d = 1'b1;
                        armed_d       = armed_q && !wrong_key;
                        timer_d       = TIMER_W'(GAP_MS);
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                BOOM: begin
                    // Watchdog: a display controller that never answers must not stall the round.
                    if (bus.boom_done || timer_q == '0) begin
                        state_d    = GAP;
                        boom_req_d = 1'b0;
                        timer_d    = TIMER_W'(GAP_MS);
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                GAP: begin
                    if (timer_q == '0) state_d = SPAWN;
                    else               timer_d = timer_q - TIMER_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1k) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            armed_q       <= 1'b1;
            level_q       <= '0;
            hit_cnt_q     <= '0;
            spawn_q       <= 1'b0;
            pos_q         <= '0;
            color_q       <= COLOR_NONE;
            boom_req_q    <= 1'b0;
            hit_strobe_q  <= 1'b0;
            hit_pts_q     <= '0;
            miss_strobe_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            armed_q       <= armed_d;
            level_q       <= level_d;
            hit_cnt_q     <= hit_cnt_d;
            spawn_q       <= spawn_d;
            pos_q         <= pos_d;
            color_q       <= color_d;
            boom_req_q    <= boom_req_d;
            hit_strobe_q  <= hit_strobe_d;
            hit_pts_q     <= hit_pts_d;
            miss_strobe_q <= miss_strobe_d;
        end
    end

    assign bus.spawn       = spawn_q;
    assign bus.pos         = pos_q;
    assign bus.color       = color_q;
    assign bus.boom_req    = boom_req_q;
    assign bus.hit_strobe  = hit_strobe_q;
    assign bus.hit_pts     = hit_pts_q;
    assign bus.miss_strobe = miss_strobe_q;
    assign bus.level       = level_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: directed moles push expected spawn/hit/miss/boom-release events
// into a scoreboard that a negedge monitor pops and compares against the DUT.
module tb_mole_scheduler;

    logic        clk1k = 1'b0;
    logic        rst_n = 1'b0;
    logic        run   = 1'b0;
    logic [15:0] key   = '0;

    mole_scheduler_if bus();

    mole_scheduler dut (
        .clk1k (clk1k),
        .rst_n (rst_n),
        .run   (run),
        .key   (key),
        .bus   (bus)
    );

    always #5 clk1k = ~clk1k;

    typedef enum int {EV_SPAWN, EV_HIT, EV_MISS, EV_BFALL} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        int         cyc;
        logic [3:0] pos;
        logic [1:0] color;
        logic [2:0] level;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  cyc = 0;
    logic [7:0] m_lfsr;
    int unsigned life_tab [8] = '{1000, 900, 800, 700, 600, 500, 400, 300};

    int         cur_spawn;
    int         cur_life;
    logic [3:0] cur_pos;
    logic [1:0] cur_color;
    int         exp_level = 0;
    int         exp_hits  = 0;

    always @(posedge clk1k) cyc <= cyc + 1;

    always @(posedge clk1k) m_lfsr <= !rst_n ? 8'h01 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[0]};

    function automatic logic [7:0] lfsr_adv(input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) r = {r[6:0], r[7] ^ r[0]};
        return r;
    endfunction

    function automatic logic [1:0] color_of(input logic [7:0] r);
        return r[1] ? {1'b1, r[0]} : 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_boom = 1'b0;

    task automatic take(input ev_kind_e k);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event @cycle %0d: got event kind %0d, expected none", cyc, k);
            return;
        end
        e = sb.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        check("level", bus.level, e.level);
        case (k)
            EV_SPAWN: begin
                check("pos", bus.pos, e.pos);
                check("color", bus.color, e.color);
            end
            EV_HIT: begin
                check("hit_pts", bus.hit_pts, e.color);
                check("boom_req_on_hit", bus.boom_req, 1'b1);
            end
            default: ;
        endcase
    endtask

    always @(negedge clk1k) begin
        if (bus.spawn === 1'b1)       take(EV_SPAWN);
        if (bus.hit_strobe === 1'b1)  take(EV_HIT);
        if (bus.miss_strobe === 1'b1) take(EV_MISS);
        if (prev_boom === 1'b1 && bus.boom_req === 1'b0) take(EV_BFALL);
        prev_boom = bus.boom_req;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk1k);
        #1;
    endtask

    task automatic wait_until(input int c);
        if (cyc > c) begin
            n_cmp++;
            n_fail++;
            $display("FAIL schedule @cycle %0d: got current cycle, expected at most %0d", cyc, c);
        end
        while (cyc < c) tick(1);
    endtask

    task automatic push(input ev_kind_e k, input int c, input logic [3:0] p,
                        input logic [1:0] col, input int lvl);
        ev_t e;
        e.kind  = k;
        e.cyc   = c;
        e.pos   = p;
        e.color = col;
        e.level = 3'(lvl);
        sb.push_back(e);
    endtask

    // Mole appears at cycle s; its position comes from the LFSR value in the SPAWN cycle s-1.
    task automatic expect_spawn(input int s);
        logic [7:0] r;
        r         = lfsr_adv(m_lfsr, s - 1 - cyc);
        cur_spawn = s;
        cur_pos   = r[7:4];
        cur_color = color_of(r);
        cur_life  = int'(life_tab[exp_level]);
        push(EV_SPAWN, s, cur_pos, cur_color, exp_level);
    endtask

    task automatic mole_miss();
        int g;
        g = cur_spawn + cur_life;
        push(EV_MISS, g, 4'd0, 2'd0, exp_level);
        expect_spawn(g + 202);
        wait_until(cur_spawn);
    endtask

    task automatic press_hit(input int c, input bit release_key);
        wait_until(c);
        key = 16'd1 << cur_pos;
        exp_hits++;
        if (exp_hits == 5) begin
            exp_hits = 0;
            if (exp_level < 7) exp_level++;
        end
        push(EV_HIT, c + 1, 4'd0, cur_color, exp_level);
        tick(1);
        if (release_key) key = '0;
    endtask

    // Called in the hit_strobe cycle; ends BOOM by boom_done or by the watchdog.
    task automatic finish_boom(input int done_after, input bit use_done);
        int h;
        int g;
        h = cyc;
        g = use_done ? h + done_after + 1 : h + 255;
        push(EV_BFALL, g, 4'd0, 2'd0, exp_level);
        expect_spawn(g + 202);
        if (use_done) begin
            wait_until(h + done_after);
            bus.boom_done = 1'b1;
            tick(1);
            bus.boom_done = 1'b0;
        end
        wait_until(cur_spawn);
    endtask

    task automatic mole_hit(input int off);
        press_hit(cur_spawn + off, 1'b1);
        finish_boom(2, 1'b1);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog @cycle %0d: got no end of stimulus, expected finish", cyc);
        $fatal(1, "bench watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        bus.boom_done = 1'b0;
        tick(3);
        check("rst_spawn", bus.spawn, 1'b0);
        check("rst_pos", bus.pos, 4'd0);
        check("rst_color", bus.color, 2'd0);
        check("rst_boom_req", bus.boom_req, 1'b0);
        check("rst_hit_strobe", bus.hit_strobe, 1'b0);
        check("rst_hit_pts", bus.hit_pts, 2'd0);
        check("rst_miss_strobe", bus.miss_strobe, 1'b0);
        check("rst_level", bus.level, 3'd0);
        rst_n = 1'b1;
        tick(2);

        // run rises: spawn two cycles later, mole left alone expires after 1000 cycles
        run = 1'b1;
        expect_spawn(cyc + 2);
        wait_until(cur_spawn);
        mole_miss();

        // hit, explosion acknowledged 50 cycles after hit_strobe
        press_hit(cur_spawn + 10, 1'b1);
        finish_boom(50, 1'b1);

        // hit, display never answers: watchdog ends BOOM after 255 cycles
        press_hit(cur_spawn + 5, 1'b1);
        finish_boom(0, 1'b0);

        // key held into the next mole, switched straight to its cell: no hit until released
        press_hit(cur_spawn + 3, 1'b0);
        finish_boom(10, 1'b1);
        key = 16'd1 << cur_pos;
        tick(20);
        key = '0;
        tick(1);
        press_hit(cyc, 1'b1);
        finish_boom(2, 1'b1);

        // fifth hit raises level to 1; next mole lives 900 cycles
        mole_hit(4);
        mole_miss();

        // hits 6..35 take the level to 7; lifetime floors at 300
        for (int i = 0; i < 30; i++) mole_hit(5);
        mole_miss();

        // hit in the final life cycle wins over expiry, then hits up to 40 keep level at 7
        press_hit(cur_spawn + cur_life - 1, 1'b1);
        finish_boom(2, 1'b1);
        for (int i = 0; i < 4; i++) mole_hit(3);

        // run drops mid-BOOM: boom_req and level clear next cycle, pos/color hold
        press_hit(cur_spawn + 5, 1'b1);
        wait_until(cyc + 20);
        run       = 1'b0;
        exp_level = 0;
        exp_hits  = 0;
        push(EV_BFALL, cyc + 1, 4'd0, 2'd0, 0);
        tick(6);
        check("idle_pos_hold", bus.pos, cur_pos);
        check("idle_color_hold", bus.color, cur_color);
        check("idle_boom_req", bus.boom_req, 1'b0);
        check("idle_level", bus.level, 3'd0);
        bus.boom_done = 1'b1;
        tick(1);
        bus.boom_done = 1'b0;
        tick(3);
        check("stale_boom_done_ignored", bus.boom_req, 1'b0);

        run = 1'b1;
        expect_spawn(cyc + 2);
        wait_until(cur_spawn);
`ifdef MOLE_SCHED_MISS_PENALTY_EN
        // wrong key ends the mole with a miss one cycle later
        wait_until(cur_spawn + 3);
        key = 16'd1 << (cur_pos + 4'd1);
        g = cur_spawn + 4;
        push(EV_MISS, g, 4'd0, 2'd0, exp_level);
        tick(1);
        key = '0;
        expect_spawn(g + 202);
        wait_until(cur_spawn);
`else
        // wrong key is ignored; the mole still runs its full 1000-cycle life
        wait_until(cur_spawn + 3);
        key = 16'd1 << (cur_pos + 4'd1);
        tick(1);
        key = '0;
        mole_miss();
`endif
        tick(2);
        g = sb.size();
        check("scoreboard_drained", g, 0);
        run = 1'b0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round sequencer for the whack-a-mole game, clocked by the 1 kHz game clock. It decides when and where each mole appears, runs the mole lifetime and the inter-mole gap, and judges key presses as hit or miss. On a hit it hands the explosion animation to the matrix display controller and waits for its completion. It raises difficulty by shortening mole lifetime every few hits; score and time bookkeeping stay in the top-level game controller.

## Interface
- LFSR_SEED, 8'h01, LFSR reset value; must be nonzero.
- BASE_LIFE_MS, 1000, mole lifetime at level 0 in clk1k cycles; range 1..4095.
- LIFE_STEP_MS, 100, lifetime reduction per level.
- MIN_LIFE_MS, 300, lifetime floor; range 1..BASE_LIFE_MS.
- GAP_MS, 200, blank cycles between moles; range 1..4095.
- HITS_PER_LEVEL, 5, hits required per level increment.
- BOOM_TIMEOUT, 255, maximum cycles to wait for boom_done.

Ports:
- clk1k  in  1  game clock, 1 kHz.
- rst_n  in  1  reset, synchronous, active-low.
- run  in  1  high while the game is in Gaming state.
- key  in  16  debounced keypad, one bit per matrix cell.
- boom_done  in  1  one-cycle pulse from the display controller when the explosion animation ends.
- spawn  out  1  one-cycle pulse when a new mole appears.
- pos  out  4  mole cell index.
- color  out  2  mole colour (RG); also the point value of the mole, never 0.
- boom_req  out  1  explosion request, held until acknowledged.
- hit_strobe  out  1  one-cycle pulse on a hit.
- hit_pts  out  2  points for the hit; valid with hit_strobe.
- miss_strobe  out  1  one-cycle pulse when a mole expires unhit.
- level  out  3  current difficulty level, 0..7.

## Operation
- States: IDLE, SPAWN, LIVE, BOOM, GAP.
- IDLE:
  - All strobes and boom_req are 0. level and the hit counter are cleared.
  - run=1 moves to SPAWN.
- SPAWN lasts 1 cycle:
  - pos <= lfsr[7:4].
  - color <= {lfsr[1], ~lfsr[1] | lfsr[0]}.
  - The life counter loads life(level)-1, where life(level) = max(BASE_LIFE_MS - level*LIFE_STEP_MS, MIN_LIFE_MS), computed without underflow.
  - Next state is LIVE.
- LIVE:
  - A hit is key == (16'b1 << pos) with armed=1. A hit latches hit_pts=color and moves to BOOM.
  - Otherwise the life counter decrements. At 0 the mole expires and the state moves to GAP with a miss.
- armed:
  - Cleared on a hit.
  - Set in any cycle where key == 0.
  - Effect: a key held across moles never scores twice.
- BOOM:
  - boom_req stays high.
  - boom_done moves to GAP.
  - If BOOM_TIMEOUT cycles pass without boom_done, the state also moves to GAP (watchdog).
- GAP: waits GAP_MS cycles, then moves to SPAWN.
- Level:
  - Every hit increments the hit counter.
  - When the counter reaches HITS_PER_LEVEL, it resets to 0 and level increments, saturating at 7.
- LFSR: 8-bit, next value {r[6:0], r[7]^r[0]}, advances every cycle outside reset.
- Boundary rules:
  - run=0 in any state moves to IDLE on the next cycle. A hit or expiry in that same cycle produces no strobe.
  - A hit in the final life cycle wins over expiry.
  - pos and color hold their values until the next SPAWN, and also through IDLE.
  - Reset mid-BOOM drops boom_req in the next cycle; a later boom_done is ignored.

## Timing
- Reset: state=IDLE, lfsr=LFSR_SEED, all outputs 0, armed=1.
- All outputs are registered.
- spawn is high in the first LIVE cycle. pos and color are valid from that cycle.
- LIVE spans exactly life(level) cycles when no hit occurs. miss_strobe is high in the first GAP cycle.
- A hit sampled in LIVE cycle c gives hit_strobe, hit_pts and boom_req rising at c+1.
- boom_req falls in the cycle after boom_done is sampled.
- From GAP entry to the next spawn pulse: GAP_MS + 2 cycles.
- From run rising in IDLE to spawn: 2 cycles.

## Configuration
- MOLE_SCHED_MISS_PENALTY_EN defined: in LIVE, any nonzero key that is not the correct one-hot value, with armed=1, ends the mole. It pulses miss_strobe, clears armed and enters GAP.
- Not defined: wrong keys are ignored and only expiry produces a miss.

## Structure
- Shared package game_pkg holds:
  - the state enum;
  - the colour encoding constants;
  - the LFSR width and tap definition;
  - the level width and maximum level, shared with the top-level game controller and the display controller.
- One sub-module: lfsr8, with a seed parameter, clk, rst_n and an 8-bit output. The top-level random source can reuse it.

## Test plan
- Reset, then run=1 at cycle 0 -> spawn at cycle 2; pos=lfsr[7:4]; color != 0; level=0.
- No key press -> miss_strobe exactly 1000 cycles after spawn; next spawn 202 cycles after miss_strobe.
- key = 1<<pos during LIVE -> hit_strobe next cycle with hit_pts=color; boom_req high. boom_done 50 cycles later -> boom_req low next cycle. Without boom_done -> GAP after 255 cycles.
- Key held from one mole into the next at the matching pos -> no second hit_strobe until key returns to 0.
- 5 hits -> level=1 and next mole life 900 cycles. 35 hits -> level=7 with life 300; further hits keep level=7.
- run=0 mid-BOOM -> IDLE, boom_req=0, level=0. With MOLE_SCHED_MISS_PENALTY_EN, a wrong key -> miss_strobe in the next cycle.
